// File: rtl/isp_tpg_if.sv
// Raw Bayer video bus: one pixel per clock, href qualifies active pixels, vsync marks the frame start.
interface isp_tpg_if #(parameter int BITS = 8);
  logic            href;
  logic            vsync;
  logic [BITS-1:0] raw;

  modport master (output href, vsync, raw);
  modport slave  (input  href, vsync, raw);
endinterface

// File: rtl/isp_tpg.sv
// Raw Bayer test-pattern generator: full frames with blanking, four selectable patterns,
// run request honoured only at frame boundaries.
module isp_tpg #(
  parameter int BITS        = 8,
  parameter int WIDTH       = 1280,
  parameter int HEIGHT      = 960,
  parameter int BAYER       = 0,
  parameter int HBLANK      = 160,
  parameter int VSYNC_LINES = 2,
  parameter int VBP_LINES   = 4,
  parameter int VFP_LINES   = 4
) (
  input  logic            pclk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [1:0]      pattern,
  input  logic [BITS-1:0] solid_val,
  isp_tpg_if.master       vid,
  output logic            frame_done,
  output logic [15:0]     frame_cnt
);

  localparam int LINE  = WIDTH + HBLANK;
  localparam int BAR_W = WIDTH / 8;
  localparam int MAXL  = (VSYNC_LINES > VBP_LINES)
                         ? ((VSYNC_LINES > VFP_LINES) ? VSYNC_LINES : VFP_LINES)
                         : ((VBP_LINES > VFP_LINES) ? VBP_LINES : VFP_LINES);
  localparam int XW    = $clog2(LINE + 1);
  localparam int YW    = $clog2(HEIGHT + 1);
  localparam int LW    = $clog2(MAXL + 1);
  localparam int BW    = $clog2(BAR_W + 1);

  localparam logic [XW-1:0]   X_LAST   = XW'(LINE - 1);
  localparam logic [XW-1:0]   X_ACT    = XW'(WIDTH);
  localparam logic [YW-1:0]   Y_LAST   = YW'(HEIGHT - 1);
  localparam logic [LW-1:0]   VS_LAST  = LW'(VSYNC_LINES - 1);
  localparam logic [LW-1:0]   VBP_LAST = LW'(VBP_LINES - 1);
  localparam logic [LW-1:0]   VFP_LAST = LW'(VFP_LINES - 1);
  localparam logic [BW-1:0]   BAR_LAST = BW'(BAR_W - 1);
  localparam logic [BITS-1:0] STEP     = BITS'((2**BITS - 1) / 7);
  localparam logic [BITS-1:0] PIX_R    = {BITS{1'b1}};
  localparam logic [BITS-1:0] PIX_G    = BITS'(2**(BITS - 1));

  typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBP, S_ACTIVE, S_VFP} state_t;

  state_t          r_state, w_state_nxt;
  logic [XW-1:0]   r_x, w_x_nxt;
  logic [LW-1:0]   r_line, w_line_nxt;
  logic [YW-1:0]   r_y, w_y_nxt;
  logic [2:0]      r_bar, w_bar_nxt;
  logic [BW-1:0]   r_bar_px, w_bar_px_nxt;
  logic [1:0]      r_pat;
  logic [BITS-1:0] r_solid;
  logic            r_href, r_vsync, r_frame_done;
  logic [BITS-1:0] r_raw, w_pix;
  logic [15:0]     r_frame_cnt;
  logic            w_frame_end, w_start, w_href_nxt, w_last_nxt;
  logic [1:0]      w_site;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_line_nxt  = r_line;
    w_y_nxt     = r_y;
    w_frame_end = 1'b0;
    w_start     = 1'b0;
    if (r_state == S_IDLE) begin
      w_x_nxt    = '0;
      w_line_nxt = '0;
      w_y_nxt    = '0;
      if (en) begin
        w_start     = 1'b1;
        w_state_nxt = S_VSYNC;
      end
    end else if (r_x != X_LAST) begin
      w_x_nxt = r_x + 1'b1;
    end else begin
      w_x_nxt    = '0;
      w_line_nxt = r_line + 1'b1;
      case (r_state)
        S_VSYNC: if (r_line == VS_LAST) begin
          w_line_nxt  = '0;
          w_state_nxt = (VBP_LINES > 0) ? S_VBP : S_ACTIVE;
        end
        S_VBP: if (r_line == VBP_LAST) begin
          w_line_nxt  = '0;
          w_state_nxt = S_ACTIVE;
        end
        S_ACTIVE: begin
          w_line_nxt = '0;
          if (r_y != Y_LAST)      w_y_nxt     = r_y + 1'b1;
          else if (VFP_LINES > 0) w_state_nxt = S_VFP;
          else                    w_frame_end = 1'b1;
        end
        S_VFP: if (r_line == VFP_LAST) w_frame_end = 1'b1;
        default: w_state_nxt = S_IDLE;
      endcase
      // Frames chain straight into the next vsync when still enabled, relatching the pattern.
      if (w_frame_end) begin
        w_line_nxt = '0;
        w_y_nxt    = '0;
        if (en) begin
          w_start     = 1'b1;
          w_state_nxt = S_VSYNC;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
    end
  end

  // Bar index tracks x with a small sub-counter instead of dividing by WIDTH/8.
  always_comb begin
    w_bar_nxt    = r_bar;
    w_bar_px_nxt = r_bar_px;
    if (w_x_nxt == '0) begin
      w_bar_nxt    = '0;
      w_bar_px_nxt = '0;
    end else if (r_bar_px == BAR_LAST) begin
      w_bar_nxt    = r_bar + 1'b1;
      w_bar_px_nxt = '0;
    end else begin
      w_bar_px_nxt = r_bar_px + 1'b1;
    end
  end

  // Outputs are registered from next-cycle position so href, vsync and raw all line up.
  always_comb begin
    w_href_nxt = (w_state_nxt == S_ACTIVE) && (w_x_nxt < X_ACT);
    w_last_nxt = (w_x_nxt == X_LAST) &&
                 (((w_state_nxt == S_VFP) && (w_line_nxt == VFP_LAST)) ||
                  ((VFP_LINES == 0) && (w_state_nxt == S_ACTIVE) && (w_y_nxt == Y_LAST)));
    w_site     = {w_y_nxt[0], w_x_nxt[0]} ^ 2'(BAYER);
    case (r_pat)
      2'd0:    w_pix = r_solid;
      2'd1:    w_pix = BITS'(w_x_nxt) + BITS'(r_frame_cnt);
      2'd2:    w_pix = BITS'(w_bar_nxt) * STEP;
      default: w_pix = (w_site == 2'd0) ? PIX_R : (w_site == 2'd3) ? '0 : PIX_G;
    endcase
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_x          <= '0;
      r_line       <= '0;
      r_y          <= '0;
      r_bar        <= '0;
      r_bar_px     <= '0;
      r_pat        <= '0;
      r_solid      <= '0;
      r_href       <= 1'b0;
      r_vsync      <= 1'b0;
      r_raw        <= '0;
      r_frame_done <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_x          <= w_x_nxt;
      r_line       <= w_line_nxt;
      r_y          <= w_y_nxt;
      r_bar        <= w_bar_nxt;
      r_bar_px     <= w_bar_px_nxt;
      if (w_start) begin
        r_pat   <= pattern;
        r_solid <= solid_val;
      end
      r_href       <= w_href_nxt;
      r_vsync      <= (w_state_nxt == S_VSYNC);
      r_raw        <= w_href_nxt ? w_pix : '0;
      r_frame_done <= w_last_nxt;
      if (w_last_nxt) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign vid.href   = r_href;
  assign vid.vsync  = r_vsync;
  assign vid.raw    = r_raw;
  assign frame_done = r_frame_done;
  assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_isp_tpg.sv
// Directed bench for isp_tpg on a 16x4 frame (LINE=20, FRAME=140); two instances cover BAYER 0 and 3.
module tb_isp_tpg;
  localparam int BITS  = 8;
  localparam int WIDTH = 16;
  localparam int LINE  = 20;
  localparam int FRAME = 140;

  logic        pclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [1:0]  pattern = 2'd0;
  logic [7:0]  solid_val = 8'h00;
  logic        frame_done, frame_done3;
  logic [15:0] frame_cnt, frame_cnt3;

  isp_tpg_if #(.BITS(BITS)) vid ();
  isp_tpg_if #(.BITS(BITS)) vid3 ();

  isp_tpg #(.BITS(BITS), .WIDTH(WIDTH), .HEIGHT(4), .BAYER(0), .HBLANK(4),
            .VSYNC_LINES(1), .VBP_LINES(1), .VFP_LINES(1)) dut (
    .pclk(pclk), .rst_n(rst_n), .en(en), .pattern(pattern), .solid_val(solid_val),
    .vid(vid), .frame_done(frame_done), .frame_cnt(frame_cnt));

  isp_tpg #(.BITS(BITS), .WIDTH(WIDTH), .HEIGHT(4), .BAYER(3), .HBLANK(4),
            .VSYNC_LINES(1), .VBP_LINES(1), .VFP_LINES(1)) dut3 (
    .pclk(pclk), .rst_n(rst_n), .en(en), .pattern(pattern), .solid_val(solid_val),
    .vid(vid3), .frame_done(frame_done3), .frame_cnt(frame_cnt3));

  always #5 pclk = ~pclk;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] exp_cnt = 16'd0;

  logic        cap_vs [1:FRAME];
  logic        cap_hr [1:FRAME];
  logic        cap_fd [1:FRAME];
  logic [7:0]  cap_raw [1:FRAME];
  logic [7:0]  cap_raw3 [1:FRAME];
  logic [15:0] cap_cnt;
  int          cap_wait;

  function automatic logic exp_vs(int c);
    return ((c - 1) / LINE) == 0;
  endfunction

  function automatic logic exp_hr(int c);
    int l = (c - 1) / LINE;
    return (l >= 2) && (l <= 5) && (((c - 1) % LINE) < WIDTH);
  endfunction

  function automatic logic [7:0] exp_pix(int pat, logic [15:0] k, int bayer, logic [7:0] solid, int c);
    int    row = (c - 1) / LINE - 2;
    int    x = (c - 1) % LINE;
    string s;
    byte   ch;
    case (pat)
      0: return solid;
      1: return 8'(x) + k[7:0];
      2: return 8'((x / 2) * 36);
      default: begin
        case (bayer)
          0: s = "RGGB";
          1: s = "GRBG";
          2: s = "GBRG";
          default: s = "BGGR";
        endcase
        ch = s[(row % 2) * 2 + (x % 2)];
        return (ch == "R") ? 8'd255 : (ch == "G") ? 8'd128 : 8'd0;
      end
    endcase
  endfunction

  // Waits (bounded) for the first vsync cycle, then records one whole frame sampled at negedges.
  task automatic capture_frame();
    int w = 0;
    @(negedge pclk);
    while (vid.vsync !== 1'b1 && w < 400) begin
      @(negedge pclk);
      w++;
    end
    cap_wait = w;
    for (int c = 1; c <= FRAME; c++) begin
      cap_vs[c]   = vid.vsync;
      cap_hr[c]   = vid.href;
      cap_fd[c]   = frame_done;
      cap_raw[c]  = vid.raw;
      cap_raw3[c] = vid3.raw;
      if (c < FRAME) @(negedge pclk);
    end
    cap_cnt = frame_cnt;
  endtask

  task automatic diff_frame(input int pat, input logic [15:0] k, input int bayer, input logic [7:0] solid,
                            input bit use3, output int n_geom, output int n_pix,
                            output string g_msg, output string p_msg);
    logic [7:0] got, want;
    n_geom = 0; n_pix = 0; g_msg = ""; p_msg = "";
    for (int c = 1; c <= FRAME; c++) begin
      if (cap_vs[c] !== exp_vs(c) || cap_hr[c] !== exp_hr(c) || cap_fd[c] !== (c == FRAME)) begin
        if (n_geom == 0)
          g_msg = $sformatf("cycle %0d vsync=%b exp %b href=%b exp %b done=%b exp %b", c,
                            cap_vs[c], exp_vs(c), cap_hr[c], exp_hr(c), cap_fd[c], (c == FRAME));
        n_geom++;
      end
      got  = use3 ? cap_raw3[c] : cap_raw[c];
      want = exp_hr(c) ? exp_pix(pat, k, bayer, solid, c) : 8'h00;
      if (got !== want) begin
        if (n_pix == 0) p_msg = $sformatf("cycle %0d raw=%0d exp %0d", c, got, want);
        n_pix++;
      end
    end
  endtask

  task automatic start_single_frame();
    en = 1'b1;
    fork
      capture_frame();
      begin @(negedge pclk); en = 1'b0; end
    join
    exp_cnt = exp_cnt + 16'd1;
  endtask

  task automatic test_reset();
    int bad = 0;
    rst_n = 1'b0; en = 1'b0;
    repeat (3) @(negedge pclk);
    n_checks++;
    if ({vid.href, vid.vsync, vid.raw, frame_done, frame_cnt} !== 27'd0) begin
      n_fail++;
      $display("FAIL reset_state: href=%b vsync=%b raw=%0d done=%b cnt=%0d, all required 0",
               vid.href, vid.vsync, vid.raw, frame_done, frame_cnt);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(negedge pclk);
      if ({vid.href, vid.vsync, vid.raw, frame_done, frame_cnt} !== 27'd0) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL idle_quiet: %0d of 500 idle cycles had nonzero outputs, required 0", bad);
    end
  endtask

  task automatic test_geometry();
    int ng, np, vs_len = 0, bursts = 0, bad_len = 0, run = 0, first_hr = 0, overlap = 0, busy = 0;
    string gm, pm;
    pattern = 2'd0; solid_val = 8'h5A;
    start_single_frame();
    n_checks++;
    if (cap_wait !== 0) begin
      n_fail++; $display("FAIL geom_vsync_latency: %0d extra cycles, required 0", cap_wait);
    end
    for (int c = 1; c <= FRAME; c++) begin
      if (cap_vs[c]) vs_len++;
      if (cap_vs[c] && cap_hr[c]) overlap++;
      if (cap_hr[c] && first_hr == 0) first_hr = c;
      if (cap_hr[c]) run++;
      if (!cap_hr[c] && run != 0) begin
        bursts++;
        if (run != 16) bad_len++;
        run = 0;
      end
    end
    n_checks++;
    if (vs_len !== 20) begin n_fail++; $display("FAIL geom_vsync_len: %0d cycles, required 20", vs_len); end
    n_checks++;
    if (first_hr !== 41) begin n_fail++; $display("FAIL geom_first_href: cycle %0d, required 41", first_hr); end
    n_checks++;
    if (bursts !== 4 || bad_len !== 0) begin
      n_fail++; $display("FAIL geom_bursts: %0d bursts (%0d wrong length), required 4 of 16", bursts, bad_len);
    end
    n_checks++;
    if (overlap !== 0) begin n_fail++; $display("FAIL geom_overlap: %0d cycles vsync&href, required 0", overlap); end
    diff_frame(0, exp_cnt, 0, 8'h5A, 1'b0, ng, np, gm, pm);
    n_checks++;
    if (ng !== 0) begin n_fail++; $display("FAIL geom_timeline: %0d cycles differ, first %s", ng, gm); end
    n_checks++;
    if (np !== 0) begin n_fail++; $display("FAIL geom_solid_pixels: %0d differ, first %s", np, pm); end
    n_checks++;
    if (cap_cnt !== exp_cnt) begin n_fail++; $display("FAIL geom_frame_cnt: %0d, required %0d", cap_cnt, exp_cnt); end
    for (int i = 0; i < 100; i++) begin
      @(negedge pclk);
      if (vid.vsync || vid.href || frame_done) busy++;
    end
    n_checks++;
    if (busy !== 0) begin n_fail++; $display("FAIL geom_then_idle: %0d busy cycles, required 0", busy); end
  endtask

  task automatic test_colour_bars();
    int ng, np;
    string gm, pm;
    pattern = 2'd2; solid_val = 8'h11;
    start_single_frame();
    diff_frame(2, exp_cnt, 0, 8'h11, 1'b0, ng, np, gm, pm);
    n_checks++;
    if (np !== 0) begin n_fail++; $display("FAIL bars_pixels: %0d differ, first %s", np, pm); end
    n_checks++;
    if (ng !== 0) begin n_fail++; $display("FAIL bars_timeline: %0d differ, first %s", ng, gm); end
    repeat (20) @(negedge pclk);
  endtask

  task automatic test_bayer();
    int ng, np, ng3, np3;
    string gm, pm, gm3, pm3;
    pattern = 2'd3;
    start_single_frame();
    diff_frame(3, exp_cnt, 0, 8'h00, 1'b0, ng, np, gm, pm);
    diff_frame(3, exp_cnt, 3, 8'h00, 1'b1, ng3, np3, gm3, pm3);
    n_checks++;
    if (np !== 0) begin n_fail++; $display("FAIL bayer_rggb: %0d differ, first %s", np, pm); end
    n_checks++;
    if (np3 !== 0) begin n_fail++; $display("FAIL bayer_bggr: %0d differ, first %s", np3, pm3); end
    n_checks++;
    if (cap_cnt !== exp_cnt) begin n_fail++; $display("FAIL bayer_frame_cnt: %0d, required %0d", cap_cnt, exp_cnt); end
    repeat (20) @(negedge pclk);
  endtask

  task automatic test_ramp_continuous();
    int ng, np, w = 0;
    string gm, pm;
    pattern = 2'd1; en = 1'b1;
    for (int f = 0; f < 2; f++) begin
      capture_frame();
      diff_frame(1, exp_cnt, 0, 8'h00, 1'b0, ng, np, gm, pm);
      exp_cnt = exp_cnt + 16'd1;
      n_checks++;
      if (cap_wait !== 0) begin
        n_fail++; $display("FAIL ramp_gap_f%0d: %0d idle cycles before vsync, required 0", f, cap_wait);
      end
      n_checks++;
      if (np !== 0 || ng !== 0) begin
        n_fail++; $display("FAIL ramp_frame_f%0d: %0d pixel, %0d timing diffs; %s %s", f, np, ng, pm, gm);
      end
      n_checks++;
      if (cap_cnt !== exp_cnt) begin n_fail++; $display("FAIL ramp_cnt_f%0d: %0d, required %0d", f, cap_cnt, exp_cnt); end
    end
    repeat (10) @(negedge pclk);
    force dut.r_frame_cnt = 16'hFFFE;
    @(negedge pclk);
    release dut.r_frame_cnt;
    exp_cnt = 16'hFFFF;
    while (frame_done !== 1'b1 && w < 300) begin
      @(negedge pclk);
      w++;
    end
    n_checks++;
    if (frame_cnt !== exp_cnt) begin n_fail++; $display("FAIL ramp_preload: cnt=%0d, required %0d", frame_cnt, exp_cnt); end
    capture_frame();
    diff_frame(1, exp_cnt, 0, 8'h00, 1'b0, ng, np, gm, pm);
    exp_cnt = exp_cnt + 16'd1;
    n_checks++;
    if (np !== 0 || cap_wait !== 0) begin
      n_fail++; $display("FAIL ramp_near_wrap: %0d pixel diffs, gap %0d; %s", np, cap_wait, pm);
    end
    n_checks++;
    if (cap_cnt !== 16'd0) begin n_fail++; $display("FAIL ramp_cnt_wrap: %0d, required 0", cap_cnt); end
  endtask

  task automatic test_mid_frame();
    int ng, np, busy = 0;
    string gm, pm;
    fork
      capture_frame();
      begin
        repeat (70) @(negedge pclk);
        en = 1'b0; pattern = 2'd2; solid_val = 8'hC3;
      end
    join
    diff_frame(1, exp_cnt, 0, 8'h00, 1'b0, ng, np, gm, pm);
    exp_cnt = exp_cnt + 16'd1;
    n_checks++;
    if (np !== 0) begin n_fail++; $display("FAIL mid_pattern_change: %0d differ, first %s", np, pm); end
    n_checks++;
    if (ng !== 0 || cap_wait !== 0) begin
      n_fail++; $display("FAIL mid_en_drop_frame: %0d diffs gap %0d, first %s", ng, cap_wait, gm);
    end
    for (int i = 0; i < 300; i++) begin
      @(negedge pclk);
      if (vid.vsync || vid.href || frame_done) busy++;
    end
    n_checks++;
    if (busy !== 0 || frame_cnt !== exp_cnt) begin
      n_fail++; $display("FAIL mid_then_idle: %0d busy cycles cnt=%0d, required 0 and %0d", busy, frame_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset_mid_line();
    int ng, np, w = 0;
    string gm, pm;
    logic href_seen;
    pattern = 2'd0; solid_val = 8'h33; en = 1'b1;
    while (vid.href !== 1'b1 && w < 300) begin
      @(negedge pclk);
      w++;
    end
    repeat (4) @(negedge pclk);
    href_seen = vid.href;
    #2 rst_n = 1'b0;
    #1;
    exp_cnt = 16'd0;
    n_checks++;
    if (href_seen !== 1'b1) begin n_fail++; $display("FAIL rst_mid_line_reach: href=%b before reset, required 1", href_seen); end
    n_checks++;
    if ({vid.href, vid.vsync, vid.raw, frame_done, frame_cnt} !== 27'd0) begin
      n_fail++;
      $display("FAIL rst_async_clear: href=%b vsync=%b raw=%0d done=%b cnt=%0d, all required 0",
               vid.href, vid.vsync, vid.raw, frame_done, frame_cnt);
    end
    @(negedge pclk);
    rst_n = 1'b1;
    fork
      capture_frame();
      begin repeat (3) @(negedge pclk); en = 1'b0; end
    join
    diff_frame(0, exp_cnt, 0, 8'h33, 1'b0, ng, np, gm, pm);
    exp_cnt = exp_cnt + 16'd1;
    n_checks++;
    if (ng !== 0 || cap_wait !== 0) begin
      n_fail++; $display("FAIL rst_restart_geom: %0d diffs gap %0d, first %s", ng, cap_wait, gm);
    end
    n_checks++;
    if (np !== 0 || cap_cnt !== exp_cnt) begin
      n_fail++; $display("FAIL rst_restart_data: %0d pixel diffs cnt=%0d exp %0d; %s", np, cap_cnt, exp_cnt, pm);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_geometry();
    test_colour_bars();
    test_bayer();
    test_ramp_continuous();
    test_mid_frame();
    test_reset_mid_line();
    repeat (5) @(negedge pclk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
